// File: rtl/tdc_sequencer.sv
// Sequencer for one ring-oscillator TDC measurement: arm, start, coarse count,
// settle, fine capture and valid/ready result handoff. All outputs registered.
module tdc_sequencer #(
   parameter int COARSE_W      = 16,
   parameter int FINE_W        = 8,
   parameter int MAX_CYCLES    = 1000,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_arm,
   input  logic                i_abort,
   input  logic                i_start_evt,
   input  logic                i_stop_evt,
   input  logic [FINE_W-1:0]   i_fine_cnt,
   input  logic                i_ready,
   output logic                o_ro_nreset,
   output logic                o_ro_start,
   output logic                o_busy,
   output logic                o_valid,
   output logic [COARSE_W-1:0] o_coarse,
   output logic [FINE_W-1:0]   o_fine,
   output logic                o_timeout
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARMED  = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_SETTLE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [COARSE_W-1:0] COARSE_MAX  = COARSE_W'(MAX_CYCLES);

   logic [2:0]          state_q, state_d;
   logic [COARSE_W-1:0] coarse_q, coarse_d;
   logic [COARSE_W-1:0] coarse_inc;
   logic [FINE_W-1:0]   fine_q, fine_d;
   logic                timeout_q, timeout_d;
   logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
   logic                ro_nreset_q, ro_nreset_d;
   logic                ro_start_q, ro_start_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;

   assign coarse_inc = coarse_q + COARSE_W'(1);

   always_comb begin
      state_d      = state_q;
      coarse_d     = coarse_q;
      fine_d       = fine_q;
      timeout_d    = timeout_q;
      settle_cnt_d = settle_cnt_q;
      ro_start_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_arm) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (i_abort) begin
               state_d = ST_IDLE;
            end else if (i_start_evt) begin
               coarse_d     = '0;
               settle_cnt_d = '0;
               ro_start_d   = 1'b1;
               state_d      = i_stop_evt ? ST_SETTLE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_abort) begin
               state_d = ST_IDLE;
            end else begin
               coarse_d = coarse_inc;
               // A stop on the limit edge still counts as a real stop.
               if (i_stop_evt) begin
                  settle_cnt_d = '0;
                  state_d      = ST_SETTLE;
               end else if (coarse_inc == COARSE_MAX) begin
                  fine_d    = '0;
                  timeout_d = 1'b1;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_SETTLE: begin
            if (i_abort) begin
               state_d = ST_IDLE;
            end else if (settle_cnt_q == SETTLE_LAST) begin
               fine_d    = i_fine_cnt;
               timeout_d = 1'b0;
               state_d   = ST_DONE;
            end else begin
               settle_cnt_d = settle_cnt_q + SET_W'(1);
            end
         end
         ST_DONE: begin
            if (i_abort || (valid_q && i_ready)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      ro_nreset_d = (state_d == ST_ARMED) || (state_d == ST_RUN) || (state_d == ST_SETTLE);
      busy_d      = (state_d != ST_IDLE);
      valid_d     = (state_d == ST_DONE);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         coarse_q     <= '0;
         fine_q       <= '0;
         timeout_q    <= 1'b0;
         settle_cnt_q <= '0;
         ro_nreset_q  <= 1'b0;
         ro_start_q   <= 1'b0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         coarse_q     <= coarse_d;
         fine_q       <= fine_d;
         timeout_q    <= timeout_d;
         settle_cnt_q <= settle_cnt_d;
         ro_nreset_q  <= ro_nreset_d;
         ro_start_q   <= ro_start_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
      end
   end

   assign o_ro_nreset = ro_nreset_q;
   assign o_ro_start  = ro_start_q;
   assign o_busy      = busy_q;
   assign o_valid     = valid_q;
   assign o_coarse    = coarse_q;
   assign o_fine      = fine_q;
   assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_tdc_sequencer.sv
// Bench for tdc_sequencer: cycle vector table, directed corner cases and
// randomized measurements checked against a transaction-level timing model.
module tb_tdc_sequencer;

   localparam int CW   = 16;
   localparam int FW   = 8;
   localparam int MAXC = 1000;
   localparam int SC   = 2;

   logic          clk = 1'b0;
   logic          i_reset, i_arm, i_abort, i_start_evt, i_stop_evt, i_ready;
   logic [FW-1:0] i_fine_cnt;
   logic          o_ro_nreset, o_ro_start, o_busy, o_valid, o_timeout;
   logic [CW-1:0] o_coarse;
   logic [FW-1:0] o_fine;

   int n_tests = 0;
   int n_fail  = 0;

   tdc_sequencer #(
      .COARSE_W(CW), .FINE_W(FW), .MAX_CYCLES(MAXC), .SETTLE_CYCLES(SC)
   ) dut (
      .i_clk(clk), .i_reset(i_reset), .i_arm(i_arm), .i_abort(i_abort),
      .i_start_evt(i_start_evt), .i_stop_evt(i_stop_evt), .i_fine_cnt(i_fine_cnt),
      .i_ready(i_ready), .o_ro_nreset(o_ro_nreset), .o_ro_start(o_ro_start),
      .o_busy(o_busy), .o_valid(o_valid), .o_coarse(o_coarse), .o_fine(o_fine),
      .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   // {in: rst,arm,abort,start,stop,ready} -> {ctl: nreset,start,busy,valid}
   typedef struct {
      logic [5:0]    in;
      logic [FW-1:0] fine;
      logic [3:0]    exp_ctl;
      logic [CW-1:0] exp_coarse;
      logic [FW-1:0] exp_fine;
      logic          exp_to;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_reset = 1'b0; i_arm = 1'b0; i_abort = 1'b0;
      i_start_evt = 1'b0; i_stop_evt = 1'b0; i_ready = 1'b0;
   endtask

   function automatic logic [3:0] ctl();
      return {o_ro_nreset, o_ro_start, o_busy, o_valid};
   endfunction

   function automatic logic [28:0] all_out();
      return {ctl(), o_coarse, o_fine, o_timeout};
   endfunction

   // Model: a stop n edges after start gives coarse=n, valid n+SC edges after
   // start; no stop gives coarse=MAX, fine=0, timeout=1, valid MAX edges after start.
   task automatic run_txn(input int start_gap, input int stop_n, input logic [FW-1:0] fine_val,
                          input int ready_gap, input bit spurious);
      bit            to_exp;
      int            exp_edge;
      logic [CW-1:0] exp_coarse;
      logic [FW-1:0] exp_fine;
      int            first_valid;
      bit            extra_start;
      bit            held;
      logic [28:0]   snap;
      to_exp      = (stop_n < 0);
      exp_coarse  = to_exp ? CW'(MAXC) : CW'(stop_n);
      exp_fine    = to_exp ? '0 : fine_val;
      exp_edge    = to_exp ? MAXC : stop_n + SC;
      first_valid = -1;
      extra_start = 1'b0;
      held        = 1'b1;

      i_arm = 1'b1; step(); i_arm = 1'b0;
      chk("arm_ctl", 64'(ctl()), 64'(4'b1010));
      for (int g = 1; g < start_gap; g++) begin
         i_stop_evt = spurious && (g == 1);
         step();
      end
      i_start_evt = 1'b1; i_stop_evt = (stop_n == 0);
      step();
      i_start_evt = 1'b0; i_stop_evt = 1'b0;
      chk("start_pulse", 64'(o_ro_start), 64'(1'b1));

      for (int j = 1; j <= exp_edge && first_valid < 0; j++) begin
         i_stop_evt  = (j == stop_n);
         i_start_evt = spurious && (j == 3);
         i_fine_cnt  = (j == exp_edge && !to_exp) ? fine_val : FW'($urandom);
         step();
         if (o_ro_start) extra_start = 1'b1;
         if (o_valid) first_valid = j;
      end
      i_stop_evt = 1'b0; i_start_evt = 1'b0;
      chk("valid_edge", 64'(first_valid), 64'(exp_edge));
      chk("no_restart", 64'(extra_start), 64'(1'b0));
      chk("result", 64'({o_coarse, o_fine, o_timeout}), 64'({exp_coarse, exp_fine, to_exp}));
      chk("done_ctl", 64'(ctl()), 64'(4'b0011));

      snap = all_out();
      for (int r = 0; r < ready_gap; r++) begin
         i_arm = (r == 0);
         i_fine_cnt = FW'($urandom);
         step();
         if (all_out() !== snap) held = 1'b0;
      end
      i_arm = 1'b0;
      chk("backpressure_hold", 64'(held), 64'(1'b1));
      i_ready = 1'b1; step(); i_ready = 1'b0;
      chk("handshake", 64'(all_out()), 64'({4'b0000, exp_coarse, exp_fine, to_exp}));
   endtask

   initial begin
      bit saw_valid;
      idle_inputs();
      i_fine_cnt = '0;

      vecs[0]  = '{6'b100000, 8'h00, 4'b0000, 16'd0, 8'h00, 1'b0};
      vecs[1]  = '{6'b000000, 8'h00, 4'b0000, 16'd0, 8'h00, 1'b0};
      vecs[2]  = '{6'b000001, 8'h00, 4'b0000, 16'd0, 8'h00, 1'b0};
      vecs[3]  = '{6'b010000, 8'h00, 4'b1010, 16'd0, 8'h00, 1'b0};
      vecs[4]  = '{6'b000010, 8'h00, 4'b1010, 16'd0, 8'h00, 1'b0};
      vecs[5]  = '{6'b010000, 8'h00, 4'b1010, 16'd0, 8'h00, 1'b0};
      vecs[6]  = '{6'b000100, 8'h00, 4'b1110, 16'd0, 8'h00, 1'b0};
      vecs[7]  = '{6'b000000, 8'h00, 4'b1010, 16'd1, 8'h00, 1'b0};
      vecs[8]  = '{6'b000100, 8'h00, 4'b1010, 16'd2, 8'h00, 1'b0};
      vecs[9]  = '{6'b000001, 8'h00, 4'b1010, 16'd3, 8'h00, 1'b0};
      vecs[10] = '{6'b000010, 8'h00, 4'b1010, 16'd4, 8'h00, 1'b0};
      vecs[11] = '{6'b000000, 8'h11, 4'b1010, 16'd4, 8'h00, 1'b0};
      vecs[12] = '{6'b000000, 8'h22, 4'b0011, 16'd4, 8'h22, 1'b0};
      vecs[13] = '{6'b010000, 8'h33, 4'b0011, 16'd4, 8'h22, 1'b0};
      vecs[14] = '{6'b000001, 8'h33, 4'b0000, 16'd4, 8'h22, 1'b0};
      vecs[15] = '{6'b010000, 8'h00, 4'b1010, 16'd4, 8'h22, 1'b0};
      vecs[16] = '{6'b000110, 8'h00, 4'b1110, 16'd0, 8'h22, 1'b0};
      vecs[17] = '{6'b000000, 8'h44, 4'b1010, 16'd0, 8'h22, 1'b0};
      vecs[18] = '{6'b000000, 8'h03, 4'b0011, 16'd0, 8'h03, 1'b0};
      vecs[19] = '{6'b001000, 8'h00, 4'b0000, 16'd0, 8'h03, 1'b0};

      for (int i = 0; i < 20; i++) begin
         {i_reset, i_arm, i_abort, i_start_evt, i_stop_evt, i_ready} = vecs[i].in;
         i_fine_cnt = vecs[i].fine;
         step();
         chk($sformatf("vec[%0d]", i), 64'(all_out()),
             64'({vecs[i].exp_ctl, vecs[i].exp_coarse, vecs[i].exp_fine, vecs[i].exp_to}));
      end
      idle_inputs();
      step();

      run_txn(10, 37, 8'h5A, 5, 1'b0);
      run_txn(3, 8, 8'hC7, 2, 1'b1);
      run_txn(2, 0, 8'h03, 1, 1'b0);
      run_txn(1, -1, 8'hEE, 5, 1'b0);

      // Abort in RUN at coarse=12
      i_arm = 1'b1; step(); i_arm = 1'b0;
      i_start_evt = 1'b1; step(); i_start_evt = 1'b0;
      repeat (12) step();
      chk("abort_coarse", 64'(o_coarse), 64'(12));
      i_abort = 1'b1; step(); i_abort = 1'b0;
      chk("abort_ctl", 64'(ctl()), 64'(4'b0000));
      saw_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (o_valid) saw_valid = 1'b1;
      end
      chk("abort_no_valid", 64'(saw_valid), 64'(1'b0));

      // Reset while in SETTLE (timeout flag still set from the previous run)
      i_arm = 1'b1; step(); i_arm = 1'b0;
      i_start_evt = 1'b1; step(); i_start_evt = 1'b0;
      repeat (4) step();
      i_stop_evt = 1'b1; step(); i_stop_evt = 1'b0;
      chk("pre_reset_coarse", 64'(o_coarse), 64'(5));
      i_fine_cnt = 8'h77; step();
      i_reset = 1'b1; step(); i_reset = 1'b0;
      chk("reset_in_settle", 64'(all_out()), 64'(0));
      step();

      for (int t = 0; t < 12; t++) begin
         run_txn(int'($urandom_range(1, 6)), int'($urandom_range(0, 40)),
                 FW'($urandom), int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tdc_sequencer.md
# tdc_sequencer

Synchronous controller that sequences one ring-oscillator time-to-digital measurement. It holds the oscillator in reset while idle, releases it on arm, and issues the oscillator start pulse when the start event arrives. It counts whole clock cycles until the stop event, waits for the fine ring-edge count to settle, and presents a coarse/fine result through a valid/ready handshake. It sits between the ring oscillator with its edge counter and the result readout logic.

## Interface
- COARSE_W, 16, width of the coarse cycle counter.
- FINE_W, 8, width of the fine ring-edge count.
- MAX_CYCLES, 1000, timeout limit in clock cycles; must satisfy 1 ≤ MAX_CYCLES < 2^COARSE_W.
- SETTLE_CYCLES, 2, wait between stop and fine capture; must be ≥ 1.

- i_clk  in  1  clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_arm  in  1  single-cycle request to begin a measurement.
- i_abort  in  1  abandons the current measurement.
- i_start_evt  in  1  start event, already synchronous to i_clk.
- i_stop_evt  in  1  stop event, already synchronous to i_clk.
- i_fine_cnt  in  FINE_W  ring-edge count from the oscillator counter.
- i_ready  in  1  consumer accepts the result.
- o_ro_nreset  out  1  active-low oscillator reset.
- o_ro_start  out  1  oscillator start pulse.
- o_busy  out  1  high whenever the state is not IDLE.
- o_valid  out  1  result available.
- o_coarse  out  COARSE_W  whole-cycle interval.
- o_fine  out  FINE_W  captured fine count.
- o_timeout  out  1  qualifies the result: the stop event was not seen in time.

## Operation
- **States:** IDLE, ARMED, RUN, SETTLE, DONE. All outputs are registered.
- **IDLE**
  - o_ro_nreset=0.
  - i_arm → ARMED.
- **ARMED**
  - o_ro_nreset=1.
  - i_stop_evt alone is ignored.
  - i_start_evt → RUN, and the coarse count is cleared to 0.
  - i_start_evt and i_stop_evt on the same edge → SETTLE with coarse=0.
- **RUN**
  - o_ro_start=1 during the first RUN cycle only.
  - The coarse count increments on every edge.
  - i_stop_evt → SETTLE; the coarse count includes that edge's increment.
  - If the count reaches MAX_CYCLES with no stop → DONE, with o_timeout=1 and o_fine=0. SETTLE is skipped.
  - Repeated i_start_evt is ignored.
- **SETTLE**
  - Lasts SETTLE_CYCLES edges.
  - On the last of these edges, i_fine_cnt is captured into o_fine → DONE.
- **DONE**
  - o_ro_nreset=0.
  - o_valid=1; o_coarse, o_fine and o_timeout are held stable.
  - When o_valid & i_ready on an edge → IDLE.
- **Abort and arm:** i_abort in any state except IDLE → IDLE on the next edge, with no o_valid. i_arm outside IDLE is ignored.
- **Coarse arithmetic:** unsigned, no wrap; it saturates at MAX_CYCLES by construction.
- **Result register lifetime:** o_coarse, o_fine and o_timeout keep their last values after the handshake until the next capture.

## Timing
- **Reset:** i_reset overrides everything, including mid-measurement. On the following edge:
  - state=IDLE;
  - all outputs 0, i.e. o_ro_nreset=0, o_ro_start=0, o_busy=0, o_valid=0, o_coarse=0, o_fine=0, o_timeout=0.
- **Arm:** i_arm sampled at edge A → o_ro_nreset=1 and o_busy=1 after edge A.
- **Start:** i_start_evt sampled at edge K → o_ro_start high for exactly one cycle after edge K.
- **Coarse value:** stop sampled at edge K+N → o_coarse=N.
- **Stop-to-valid latency:** stop at edge S → o_fine captured at edge S+SETTLE_CYCLES → o_valid high after that edge.
- **Timeout:** o_valid rises after edge K+MAX_CYCLES; o_coarse=MAX_CYCLES.
- **Handshake:**
  - o_valid stays high until the edge where i_ready=1; it drops after that edge.
  - i_ready while o_valid=0 has no effect.
  - The earliest next arm is accepted one edge after the handshake edge.
- **Abort in DONE:** abort takes priority over the handshake; o_valid drops with no transfer counted.

## Test plan
- **Basic measurement** (defaults): arm, start at edge 10, stop at edge 47, i_fine_cnt=0x5A. Expect:
  - o_ro_start pulse after edge 10;
  - o_valid after edge 49, with o_coarse=37, o_fine=0x5A, o_timeout=0;
  - o_ro_nreset=0 in DONE.
- **Simultaneous start/stop:** start and stop on the same edge, i_fine_cnt=3 → o_coarse=0, o_fine=3, o_valid after 2 further edges.
- **Timeout:** arm and start, with no stop → o_valid after edge start+1000, o_coarse=1000, o_fine=0, o_timeout=1.
- **Backpressure:**
  - hold i_ready=0 for 5 cycles in DONE → o_valid and the result stay stable;
  - an i_arm pulse during DONE is ignored;
  - i_ready=1 → IDLE, and o_busy=0 after the next edge.
- **Abort and reset mid-operation:**
  - i_abort in RUN at coarse=12 → IDLE next edge, no o_valid.
  - i_reset in SETTLE → all outputs 0 after the next edge.
- **Spurious events:**
  - stop pulse in ARMED is ignored;
  - second start pulse in RUN is ignored, and o_ro_start is not reissued;
  - subsequent stop at start+8 → o_coarse=8.
